imm_ext_pipe: RTL and testbench

Registered, parametrised immediate-extension stage for the CPU31 decode path. It replaces the fixed 16→32 zero extender with four modes: zero, sign, upper-load shift and shift-amount. A one-cycle pipeline register with a valid/ready handshake and a two-entry skid buffer sits between decode and execute, so downstream stalls never combinationally back-propagate. A tag travels alongside each immediate, typically the destination register index.

---
 rtl/imm_ext_pkg.sv | 16 +
 rtl/imm_ext_core.sv | 27 ++
 rtl/imm_ext_pipe.sv | 106 ++++++++++
 tb/tb_imm_ext_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension stage: mode encoding and
// default datapath widths.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO  = 2'd0,
    MODE_SIGN  = 2'd1,
    MODE_UPPER = 2'd2,
    MODE_SHAMT = 2'd3
  } imm_mode_e;

  localparam int IMM_W   = 16;
  localparam int WORD_W  = 32;
  localparam int SHAMT_W = 5;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender; shared by the decode pipe and the
// branch-offset path.
module imm_ext_core #(
  parameter int IN_W    = imm_ext_pkg::IMM_W,
  parameter int OUT_W   = imm_ext_pkg::WORD_W,
  parameter int SHAMT_W = imm_ext_pkg::SHAMT_W
) (
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic [OUT_W-1:0] out_ext
);
  import imm_ext_pkg::*;

  localparam int PAD_W = OUT_W - IN_W;

  always_comb begin
    out_ext = '0;
    case (imm_mode_e'(in_mode))
      MODE_ZERO:  out_ext = {{PAD_W{1'b0}}, in_imm};
      MODE_SIGN:  out_ext = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
      MODE_UPPER: out_ext = {in_imm, {PAD_W{1'b0}}};
      MODE_SHAMT: out_ext = {{(OUT_W-SHAMT_W){1'b0}}, in_imm[SHAMT_W-1:0]};
      default:    out_ext = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage with a valid/ready handshake and a
// two-entry (main + skid) buffer so out_ready never reaches in_ready combinationally.
module imm_ext_pipe #(
  parameter int IN_W    = imm_ext_pkg::IMM_W,
  parameter int OUT_W   = imm_ext_pkg::WORD_W,
  parameter int SHAMT_W = imm_ext_pkg::SHAMT_W,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);
  import imm_ext_pkg::*;

  logic [OUT_W-1:0] r_main_data;
  logic [TAG_W-1:0] r_main_tag;
  logic             r_main_valid;
  logic [OUT_W-1:0] r_skid_data;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_skid_valid;
  logic             r_in_ready;

  logic [OUT_W-1:0] w_ext;
  logic             w_accept;
  logic             w_drain;
  logic             w_main_free;
  logic             w_skid_valid_nxt;

  imm_ext_core #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .in_imm  (in_imm),
    .in_mode (in_mode),
    .out_ext (w_ext)
  );

  assign w_accept    = in_valid & r_in_ready;
  assign w_drain     = r_main_valid & out_ready;
  assign w_main_free = ~r_main_valid | w_drain;

  // Skid stays occupied when it refills in the same cycle it hands over to main.
  always_comb begin
    w_skid_valid_nxt = r_skid_valid;
    if (w_main_free) begin
      if (r_skid_valid) w_skid_valid_nxt = w_accept;
    end else if (w_accept) begin
      w_skid_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_data  <= '0;
      r_main_tag   <= '0;
      r_main_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_tag   <= '0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      if (w_main_free) begin
        if (r_skid_valid) begin
          r_main_data  <= r_skid_data;
          r_main_tag   <= r_skid_tag;
          r_main_valid <= 1'b1;
          if (w_accept) begin
            r_skid_data <= w_ext;
            r_skid_tag  <= in_tag;
          end
        end else if (w_accept) begin
          r_main_data  <= w_ext;
          r_main_tag   <= in_tag;
          r_main_valid <= 1'b1;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid_data <= w_ext;
        r_skid_tag  <= in_tag;
      end
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign out_tag   = r_main_tag;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed self-checking bench for imm_ext_pipe: mode table, streaming,
// stall/skid, flush, reset and a wide-parameter instance.
module tb_imm_ext_pipe;
  import imm_ext_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [11:0] w_in_imm;
  logic [1:0]  w_in_mode;
  logic [4:0]  w_in_tag;
  logic        w_out_valid;
  logic [63:0] w_out_data;
  logic [4:0]  w_out_tag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imm_ext_pipe u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  imm_ext_pipe #(.IN_W(12), .OUT_W(64), .SHAMT_W(5), .TAG_W(5)) u_wide (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_imm    (w_in_imm),
    .in_mode   (w_in_mode),
    .in_tag    (w_in_tag),
    .out_valid (w_out_valid),
    .out_ready (1'b1),
    .out_data  (w_out_data),
    .out_tag   (w_out_tag)
  );

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{16'h8001, MODE_ZERO,  5'd1, 32'h0000_8001};
    vecs[1] = '{16'h8001, MODE_SIGN,  5'd2, 32'hFFFF_8001};
    vecs[2] = '{16'h8001, MODE_UPPER, 5'd3, 32'h8001_0000};
    vecs[3] = '{16'h8001, MODE_SHAMT, 5'd4, 32'h0000_0001};
    vecs[4] = '{16'h7FFF, MODE_SIGN,  5'd5, 32'h0000_7FFF};
    vecs[5] = '{16'hFFFF, MODE_UPPER, 5'd6, 32'hFFFF_0000};
    vecs[6] = '{16'h1234, MODE_SHAMT, 5'd7, 32'h0000_0014};
    vecs[7] = '{16'hFFFF, MODE_ZERO,  5'd8, 32'h0000_FFFF};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0;
    in_tag = '0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_imm = '0; w_in_mode = '0; w_in_tag = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset out_tag", 64'(out_tag), 64'd0);

    // mode table, back to back
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_imm = vecs[i].imm; in_mode = vecs[i].mode; in_tag = vecs[i].tag;
      tick();
      check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d out_data", i), 64'(out_data), 64'(vecs[i].exp));
      check($sformatf("vec%0d out_tag", i), 64'(out_tag), 64'(vecs[i].tag));
      check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("idle out_valid", 64'(out_valid), 64'd0);

    // streaming 8 entries
    in_mode = MODE_ZERO;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_tag = 5'(i); in_imm = 16'(i * 3);
      tick();
      check($sformatf("stream%0d out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("stream%0d out_tag", i), 64'(out_tag), 64'(i));
      check($sformatf("stream%0d out_data", i), 64'(out_data), 64'(i * 3));
      check($sformatf("stream%0d in_ready", i), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream end out_valid", 64'(out_valid), 64'd0);

    // stall: entries 0,1 taken, 2 held off
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 5'd0; in_imm = 16'h00A0;
    tick();
    check("stall e0 out_valid", 64'(out_valid), 64'd1);
    check("stall e0 in_ready", 64'(in_ready), 64'd1);
    in_tag = 5'd1; in_imm = 16'h00A1;
    tick();
    check("stall e1 in_ready", 64'(in_ready), 64'd0);
    check("stall e1 out_tag", 64'(out_tag), 64'd0);
    in_tag = 5'd2; in_imm = 16'h00A2;
    tick(); tick();
    check("stall hold in_ready", 64'(in_ready), 64'd0);
    check("stall hold out_tag", 64'(out_tag), 64'd0);
    check("stall hold out_data", 64'(out_data), 64'h00A0);
    out_ready = 1'b1;
    tick();
    check("release t1 out_tag", 64'(out_tag), 64'd1);
    check("release t1 out_data", 64'(out_data), 64'h00A1);
    check("release t1 in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("release t2 out_valid", 64'(out_valid), 64'd1);
    check("release t2 out_tag", 64'(out_tag), 64'd2);
    check("release t2 out_data", 64'(out_data), 64'h00A2);
    tick();
    check("release empty out_valid", 64'(out_valid), 64'd0);

    // flush with both full and a same-cycle offer
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 5'd10; tick();
    in_tag = 5'd11; tick();
    check("pre-flush in_ready", 64'(in_ready), 64'd0);
    in_tag = 5'd12; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush out_valid", 64'(out_valid), 64'd0);
    check("flush in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post-flush%0d out_valid", i), 64'(out_valid), 64'd0);
    end

    // reset with main and skid full
    out_ready = 1'b0; in_imm = 16'h5555; in_mode = MODE_SIGN;
    in_valid = 1'b1; in_tag = 5'd20; tick();
    in_tag = 5'd21; tick();
    in_valid = 1'b0;
    check("pre-rst out_valid", 64'(out_valid), 64'd1);
    check("pre-rst in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_data", 64'(out_data), 64'd0);
    check("rst out_tag", 64'(out_tag), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    check("rst no ghost out_valid", 64'(out_valid), 64'd0);

    // wide instance
    w_in_valid = 1'b1; w_in_imm = 12'hFFF; w_in_mode = MODE_SIGN; w_in_tag = 5'd3;
    tick();
    check("wide sign out_valid", 64'(w_out_valid), 64'd1);
    check("wide sign out_data", w_out_data, 64'hFFFF_FFFF_FFFF_FFFF);
    w_in_mode = MODE_UPPER; w_in_tag = 5'd4;
    tick();
    check("wide upper out_data", w_out_data, 64'hFFF0_0000_0000_0000);
    check("wide upper out_tag", 64'(w_out_tag), 64'd4);
    w_in_mode = MODE_ZERO;
    tick();
    check("wide zero out_data", w_out_data, 64'h0000_0000_0000_0FFF);
    w_in_valid = 1'b0;
    tick();
    check("wide idle out_valid", 64'(w_out_valid), 64'd0);
    check("wide in_ready", 64'(w_in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
